// File: rtl/alu_prog_seq.sv
// Micro-program sequencer for the 8-bit ALU: holds a loadable {opcode, a, b} program,
// replays it one word per cycle, drains one cycle, then captures the ALU result z.
module alu_prog_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [23:0]   prog_wdata,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          abort,
  input  logic [7:0]    z,
  output logic [7:0]    opcode,
  output logic [7:0]    a,
  output logic [7:0]    b,
  output logic          busy,
  output logic          done,
  output logic [7:0]    result,
  output logic [AW-1:0] pc
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PC_ZERO = AW'(1'b0);

  logic [23:0]   mem_r [DEPTH];
  logic [1:0]    state_r;
  logic [AW:0]   len_r;
  logic [AW-1:0] pc_r;
  logic [7:0]    result_r;
  logic [23:0]   word_s;
  logic [AW:0]   len_clamped_s;
  logic          last_s;
  logic          mem_open_s;

  assign word_s        = mem_r[pc_r];
  assign len_clamped_s = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_s        = ({1'b0, pc_r} == (len_r - LEN_ONE));
  assign mem_open_s    = (state_r == ST_IDLE) || (state_r == ST_DONE);

  // Program memory write port; writes are dropped while a run is in flight.
  always_ff @(posedge clk) begin
    if (prog_we && mem_open_s) begin
      mem_r[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer state, program counter, stored length and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= PC_ZERO;
      len_r    <= {(AW+1){1'b0}};
      result_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (len == {(AW+1){1'b0}}) begin
              state_r <= ST_DONE;
            end else begin
              len_r   <= len_clamped_s;
              pc_r    <= PC_ZERO;
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // abort wins over the last-instruction transition
          if (abort) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_ZERO;
          end else if (last_s) begin
            state_r <= ST_DRAIN;
          end else begin
            pc_r <= pc_r + PC_ONE;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_ZERO;
          end else begin
            result_r <= z;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          pc_r    <= PC_ZERO;
        end
        default: begin
          state_r <= ST_IDLE;
          pc_r    <= PC_ZERO;
        end
      endcase
    end
  end

  // ALU drive: program word only while running, a nop opcode everywhere else.
  always_comb begin
    opcode = 8'h00;
    a      = 8'h00;
    b      = 8'h00;
    case (state_r)
      ST_RUN: begin
        opcode = abort ? 8'h00 : word_s[23:16];
        a      = word_s[15:8];
        b      = word_s[7:0];
      end
      default: begin
        opcode = 8'h00;
        a      = 8'h00;
        b      = 8'h00;
      end
    endcase
  end

  assign busy   = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign done   = (state_r == ST_DONE);
  assign result = result_r;
  assign pc     = pc_r;

endmodule

// File: tb/tb_alu_prog_seq.sv
// Directed bench for alu_prog_seq with a small ALU model in the loop and a
// cycle-by-cycle schedule model of the expected sequencer outputs.
module tb_alu_prog_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [23:0] prog_wdata = 24'd0;
  logic        start = 1'b0;
  logic [4:0]  len = 5'd0;
  logic        abort = 1'b0;
  logic [7:0]  z_m;
  logic [7:0]  ra_m;
  logic [7:0]  opcode, a, b, result;
  logic        busy, done;
  logic [3:0]  pc;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  alu_prog_seq #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .len(len), .abort(abort),
    .z(z_m), .opcode(opcode), .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .pc(pc)
  );

  always #5 clk = ~clk;

  // ALU stand-in: opcode[6] loads RA, opcode[7] loads z, opcode[3] selects RA as operand b.
  logic [7:0] bb_m, f_m;
  always_comb begin
    bb_m = opcode[3] ? ra_m : b;
    case (opcode[2:0])
      3'd0:    f_m = a & bb_m;
      3'd1:    f_m = a | bb_m;
      3'd2:    f_m = a + bb_m;
      3'd3:    f_m = a - bb_m;
      default: f_m = a ^ bb_m;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      z_m  <= 8'h00;
      ra_m <= 8'h00;
    end else begin
      if (opcode[6]) ra_m <= f_m;
      if (opcode[7]) z_m  <= f_m;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected-output schedule: one record per future cycle, empty queue means IDLE.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       drain;
    logic [3:0] pc;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t        q[$];
  logic [23:0] mem_m [16];
  logic [7:0]  exp_result = 8'h00;
  exp_t        cur;
  bit          front;
  int          n_run;

  function automatic exp_t mk(logic bz, logic dn, logic dr, logic [3:0] p, logic [23:0] w);
    exp_t e;
    e.busy = bz; e.done = dn; e.drain = dr; e.pc = p;
    e.op = w[23:16]; e.a = w[15:8]; e.b = w[7:0];
    return e;
  endfunction

  always @(negedge clk) begin
    front = (q.size() > 0);
    cur = front ? q[0] : mk(1'b0, 1'b0, 1'b0, 4'd0, 24'd0);
    if (abort && cur.busy) cur.op = 8'h00;
    if (chk_en) begin
      check("busy",   busy,   cur.busy);
      check("done",   done,   cur.done);
      check("pc",     pc,     cur.pc);
      check("opcode", opcode, cur.op);
      check("a",      a,      cur.a);
      check("b",      b,      cur.b);
      check("result", result, exp_result);
    end
    if (rst) begin
      q.delete();
      exp_result = 8'h00;
    end else begin
      if (front) void'(q.pop_front());
      if (abort && cur.busy) q.delete();
      else if (cur.drain) exp_result = z_m;
      if (prog_we && !cur.busy) mem_m[prog_addr] = prog_wdata;
      if (start && !front) begin
        n_run = (len > 5'd16) ? 16 : int'(len);
        if (n_run == 0) begin
          q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 24'd0));
        end else begin
          for (int k = 0; k < n_run; k++) q.push_back(mk(1'b1, 1'b0, 1'b0, 4'(k), mem_m[k]));
          q.push_back(mk(1'b1, 1'b0, 1'b1, 4'(n_run - 1), 24'd0));
          q.push_back(mk(1'b0, 1'b1, 1'b0, 4'(n_run - 1), 24'd0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] ad, input logic [23:0] w);
    prog_we = 1'b1; prog_addr = ad; prog_wdata = w;
    step();
    prog_we = 1'b0;
  endtask

  task automatic kick(input logic [4:0] l);
    start = 1'b1; len = l;
    step();
    start = 1'b0; len = 5'd0;
  endtask

  int done_cyc, busy_cnt, max_pc, done_seen;

  initial begin
    // 1. reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_opcode", opcode, 8'h00);
    check("rst_busy",   busy,   1'b0);
    check("rst_done",   done,   1'b0);
    check("rst_result", result, 8'h00);
    check("rst_pc",     pc,     4'd0);
    step();

    // 2. two-instruction chain through RA
    write_word(4'd0, {8'h42, 8'h05, 8'h07});
    write_word(4'd1, {8'h8A, 8'h03, 8'h00});
    kick(5'd2);
    done_cyc = 0; busy_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        check("chain_result", result, 8'h0F);
        break;
      end
      step();
    end
    check("chain_done_cycle", done_cyc, 4);
    check("chain_busy_cycles", busy_cnt, 3);
    step();

    // 3. zero-length run
    kick(5'd0);
    #1;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_result", result, 8'h0F);
    step();
    check("zero_done_clear", done, 1'b0);

    // 4. abort in the second RUN cycle
    for (int i = 0; i < 4; i++) write_word(4'(i), {8'h82, 8'h01, 8'h01});
    kick(5'd4);
    step();
    abort = 1'b1;
    #1;
    check("abort_opcode_forced", opcode, 8'h00);
    step();
    abort = 1'b0;
    #1;
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_pc", pc, 4'd0);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen++;
      step();
    end
    check("abort_no_done", done_seen, 0);
    check("abort_result", result, 8'h0F);

    // 5. clamped length, start/prog_we ignored while busy
    for (int i = 0; i < 16; i++) write_word(4'(i), {8'h82, 8'(i), 8'(i + 1)});
    kick(5'd17);
    busy_cnt = 0; max_pc = 0; done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin
        start = 1'b1; len = 5'd2;
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 24'hFFFFFF;
      end else begin
        start = 1'b0; len = 5'd0; prog_we = 1'b0;
      end
      #1;
      if (busy) busy_cnt++;
      if (busy && int'(pc) > max_pc) max_pc = int'(pc);
      if (done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    check("clamp_busy_cycles", busy_cnt, 17);
    check("clamp_max_pc", max_pc, 15);
    check("clamp_done_cycle", done_cyc, 18);
    check("clamp_result", result, 8'h1F);
    step();
    kick(5'd1);
    #1;
    check("mem_kept_opcode", opcode, 8'h82);
    check("mem_kept_a", a, 8'h00);
    check("mem_kept_b", b, 8'h01);
    for (int c = 0; c < 4; c++) step();

    // 6. reset in the third RUN cycle, then replay
    kick(5'd4);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_opcode", opcode, 8'h00);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_pc", pc, 4'd0);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen++;
      step();
    end
    check("mid_rst_no_done", done_seen, 0);
    kick(5'd2);
    done_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (done) begin
        done_cyc = c;
        check("replay_result", result, 8'h03);
        break;
      end
      step();
    end
    check("replay_done_cycle", done_cyc, 4);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_prog_seq.md
Name: alu_prog_seq

Overview:
- Upstream micro-program sequencer for the 8-bit ALU datapath.
- Holds a small loadable program of {opcode, a, b} words and replays it to the ALU at one instruction per cycle after a start pulse.
- Waits one drain cycle, then captures the ALU's registered result z and reports completion with a one-cycle done pulse.
- Lets software run multi-step ALU sequences (chained through the ALU's internal RA register) without cycle-accurate host control.

Parameters:
- DEPTH, 16, number of program words (power of two, 2..256).
- AW, 4, program address width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- prog_we  input  1  program write strobe.
- prog_addr  input  AW  program write address.
- prog_wdata  input  24  program word {opcode[23:16], a[15:8], b[7:0]}.
- start  input  1  begin execution; sampled only in IDLE.
- len  input  AW+1  instruction count, sampled with start; 0..DEPTH.
- abort  input  1  terminate a run early.
- z  input  8  registered ALU result, fed back from the ALU.
- opcode  output  8  opcode to the ALU.
- a  output  8  operand a to the ALU.
- b  output  8  operand b to the ALU.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle completion pulse.
- result  output  8  z captured at the end of the last run.
- pc  output  AW  current program index.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, pc=0, result=0, done=0, busy=0.
  - opcode/a/b read 0.
  - Program memory is not reset.
  - Reset mid-run abandons the run with no done pulse.
- States: IDLE, RUN, DRAIN, DONE. Registers: stored length, pc.
- IDLE:
  - opcode/a/b = 0. Opcode 0x00 holds both ALU register enables low, so ALU state is preserved.
  - start=1 with len>=1: store len (clamped to DEPTH if larger), pc<=0, go to RUN.
  - start=1 with len=0: go directly to DONE; result unchanged.
- RUN:
  - opcode/a/b driven combinationally from mem[pc]; the ALU consumes them at the next clk edge.
  - pc increments every cycle.
  - When pc == stored_len-1: go to DRAIN; pc stays put.
- DRAIN:
  - opcode/a/b = 0; z now reflects the final instruction.
  - result <= z at the end of this cycle; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE; pc<=0.
- Latency: start high in cycle 0 → instruction k is presented in cycle 1+k → done is high in cycle len+2 with result valid.
- abort=1 in RUN or DRAIN:
  - Go to IDLE next cycle; opcode forced to 0 in that same cycle; pc<=0.
  - No done pulse; result unchanged.
  - abort has priority over the RUN→DRAIN transition.
- start while busy or in DONE: ignored.
- prog_we:
  - Writes mem[prog_addr] in IDLE and DONE.
  - Dropped silently while busy.
  - A write and a start in the same IDLE cycle: the write lands first, so the run sees the new word.
- len > DEPTH: clamped to DEPTH; pc never wraps during a run.
- Memory read is asynchronous (distributed array); no read latency.

Test Plan:
1. Reset, then check all outputs: rst=1 for 2 cycles → opcode=0, busy=0, done=0, result=0x00, pc=0.
2. Two-instruction chain through RA: load word0={0x42,0x05,0x07} and word1={0x8A,0x03,0x00}, then start with len=2. Expect busy for 3 cycles, done in cycle 4 after start, result=0x0F (RA=12, then 3+12=15).
3. Zero-length run: start with len=0 → done in the next cycle, busy never high, result unchanged.
4. Abort: load 4 words with opcode 0x82, a=1, b=1, and start with len=4. Assert abort during the second RUN cycle → IDLE next cycle, opcode=0 in that same cycle, no done pulse, result unchanged.
5. Clamped length and ignored inputs: start with len=DEPTH+? (e.g. 17 with DEPTH=16) → exactly 16 RUN cycles, pc reaches 15 and does not wrap. During the run, pulse start and prog_we → both ignored; the memory word is unchanged afterwards.
6. Reset mid-run: assert rst in the third RUN cycle → IDLE, opcode=0, result=0, no done pulse. A subsequent start replays the program correctly.
